// File: rtl/i2c_target_if.sv
// Local-side port bundle of the I2C target: received-byte strobes, the read-data
// request/load handshake, status strobes and the FSM state for debug.
interface i2c_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_request;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;
  logic       stop_seen;
  logic [3:0] dbg_state;

  modport slave (
    output rx_data, rx_valid, rx_first, tx_request, busy, stop_seen, dbg_state,
    input  tx_data, tx_load
  );

  modport master (
    input  rx_data, rx_valid, rx_first, tx_request, busy, stop_seen, dbg_state,
    output tx_data, tx_load
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: answers one 7-bit address, delivers write bytes as strobes
// and stretches SCL until the local side supplies each read byte.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  inout  wire  scl,
  inout  wire  sda,
  i2c_target_if.slave lcl
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE_BYTE,
    ST_WRITE_ACK,
    ST_READ_WAIT,
    ST_READ_BYTE,
    ST_READ_ACK,
    ST_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_request_q, tx_request_d;
  logic       busy_q, busy_d;
  logic       stop_seen_q, stop_seen_d;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizers reset to 1 so an idle bus produces no spurious edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_bit_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      scl_rise_q <= scl_s & ~scl_prev_q;
      scl_fall_q <= ~scl_s & scl_prev_q;
      start_q    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_q     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      sda_bit_q  <= sda_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 7'd0;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      scl_low_q    <= 1'b0;
      sda_low_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      tx_request_q <= 1'b0;
      busy_q       <= 1'b0;
      stop_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      first_q      <= first_d;
      scl_low_q    <= scl_low_d;
      sda_low_q    <= sda_low_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      tx_request_q <= tx_request_d;
      busy_q       <= busy_d;
      stop_seen_q  <= stop_seen_d;
    end
  end

  // Read handshake: tx_request stays high while SCL is stretched; the first cycle
  // with tx_load high transfers tx_data and drops the request. No timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    first_d      = first_q;
    scl_low_d    = scl_low_q;
    sda_low_d    = sda_low_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = rx_first_q;
    tx_request_d = tx_request_q;
    busy_d       = busy_q;
    stop_seen_d  = 1'b0;

    if (start_q) begin
      state_d      = ST_ADDR;
      scl_low_d    = 1'b0;
      sda_low_d    = 1'b0;
      busy_d       = 1'b0;
      tx_request_d = 1'b0;
      cnt_d        = 3'd0;
    end else if (stop_q) begin
      state_d      = ST_IDLE;
      scl_low_d    = 1'b0;
      sda_low_d    = 1'b0;
      busy_d       = 1'b0;
      tx_request_d = 1'b0;
      cnt_d        = 3'd0;
      stop_seen_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise_q) begin
            shift_d = {shift_q[5:0], sda_bit_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_q == ADDRESS) begin
                rw_d    = sda_bit_q;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        // sda_low_q tells the two ACK-slot falls apart: first drives, second releases.
        ST_ADDR_ACK: begin
          if (scl_fall_q) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd0;
              if (rw_q) begin
                state_d      = ST_READ_WAIT;
                scl_low_d    = 1'b1;
                tx_request_d = 1'b1;
              end else begin
                state_d = ST_WRITE_BYTE;
                first_d = 1'b1;
              end
            end
          end
        end
        ST_WRITE_BYTE: begin
          if (scl_rise_q) begin
            shift_d = {shift_q[5:0], sda_bit_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q, sda_bit_q};
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              state_d    = ST_WRITE_ACK;
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall_q) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              state_d   = ST_WRITE_BYTE;
            end
          end
        end
        // SCL stays held for the load cycle so SDA settles before the release.
        ST_READ_WAIT: begin
          scl_low_d    = 1'b1;
          tx_request_d = 1'b1;
          if (lcl.tx_load) begin
            shift_d      = lcl.tx_data[6:0];
            sda_low_d    = ~lcl.tx_data[7];
            tx_request_d = 1'b0;
            cnt_d        = 3'd0;
            state_d      = ST_READ_BYTE;
          end
        end
        ST_READ_BYTE: begin
          scl_low_d = 1'b0;
          if (scl_fall_q) begin
            if (cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = ST_READ_ACK;
            end else begin
              sda_low_d = ~shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              cnt_d     = cnt_q + 3'd1;
            end
          end
        end
        // A fall here can only follow a rise that sampled ACK (NACK already left).
        ST_READ_ACK: begin
          if (scl_rise_q && sda_bit_q) begin
            state_d = ST_IGNORE;
          end else if (scl_fall_q) begin
            state_d      = ST_READ_WAIT;
            scl_low_d    = 1'b1;
            tx_request_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign scl = scl_low_q ? 1'b0 : 1'bz;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign lcl.rx_data    = rx_data_q;
  assign lcl.rx_valid   = rx_valid_q;
  assign lcl.rx_first   = rx_first_q;
  assign lcl.tx_request = tx_request_q;
  assign lcl.busy       = busy_q;
  assign lcl.stop_seen  = stop_seen_q;
  assign lcl.dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level bus initiator model on pulled-up
// open-drain lines plus a local-side responder that answers read requests.
module tb_i2c_target;
  localparam int Q = 16;

  logic clock = 1'b0;
  logic reset;
  always #10 clock = ~clock;

  wire  scl, sda;
  logic m_scl_low, m_sda_low;
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);

  i2c_target_if lcl ();

  i2c_target #(.ADDRESS(7'h42), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .lcl   (lcl)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  // Monitor-owned logs and counters; tests only read them as deltas.
  logic [7:0] rx_log[64];
  logic       rx_first_log[64];
  int rx_cnt = 0;
  int stop_cnt = 0;
  int busy_hi_cnt = 0;
  int dut_sda_low_cnt = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  // Responder-owned state.
  logic       resp_en = 1'b0;
  logic [7:0] tx_src[4];
  int tx_idx = 0;
  int stretch_low_cnt = 0;
  logic resp_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (lcl.rx_valid === 1'b1) begin
        if (rx_cnt < 64) begin
          rx_log[rx_cnt] = lcl.rx_data;
          rx_first_log[rx_cnt] = lcl.rx_first;
        end
        rx_cnt++;
      end
      if (lcl.stop_seen === 1'b1) stop_cnt++;
      if (lcl.busy === 1'b1) busy_hi_cnt++;
      if (!m_sda_low && sda === 1'b0) dut_sda_low_cnt++;
      if (lcl.tx_request === 1'b1 && !req_prev) req_rises++;
      req_prev = lcl.tx_request;
    end
  end

  initial begin
    lcl.tx_load = 1'b0;
    lcl.tx_data = 8'h00;
    forever begin
      @(negedge clock);
      if (resp_en && lcl.tx_request === 1'b1 && !resp_prev) begin
        repeat (20) @(negedge clock);
        if (scl === 1'b0) stretch_low_cnt++;
        lcl.tx_data = tx_src[tx_idx % 4];
        tx_idx++;
        lcl.tx_load = 1'b1;
        @(negedge clock);
        lcl.tx_load = 1'b0;
      end
      resp_prev = lcl.tx_request;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_scl_high(output int waited);
    waited = 0;
    while (scl !== 1'b1 && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 3000) begin
      total_cnt++;
      $display("FAIL scl_timeout: scl=%b after %0d clocks, required 1", scl, waited);
    end
  endtask

  task automatic m_bit_write(input logic b);
    int w;
    m_sda_low = ~b;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high(w);
    tick(2 * Q);
    m_scl_low = 1'b1;
    tick(4);
  endtask

  task automatic m_bit_read(output logic b, output int w);
    m_sda_low = 1'b0;
    tick(4);
    m_scl_low = 1'b0;
    wait_scl_high(w);
    tick(Q);
    b = sda;
    tick(Q);
    m_scl_low = 1'b1;
    tick(4);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic b;
    int w;
    for (int i = 7; i >= 0; i--) m_bit_write(d[i]);
    m_bit_read(b, w);
    ack = ~b;
  endtask

  task automatic m_read_byte(input logic send_ack, output logic [7:0] d, output int first_wait);
    logic b;
    int w;
    first_wait = 0;
    for (int i = 7; i >= 0; i--) begin
      m_bit_read(b, w);
      d[i] = b;
      if (i == 7) first_wait = w;
    end
    m_bit_write(~send_ack);
  endtask

  task automatic m_start();
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(4);
  endtask

  task automatic m_rstart();
    int w;
    m_sda_low = 1'b0;
    tick(4);
    m_scl_low = 1'b0;
    wait_scl_high(w);
    tick(Q);
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(4);
  endtask

  task automatic m_stop();
    int w;
    m_sda_low = 1'b1;
    tick(4);
    m_scl_low = 1'b0;
    wait_scl_high(w);
    tick(Q);
    m_sda_low = 1'b0;
    tick(Q);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    total_cnt++;
    if ({lcl.rx_data, lcl.rx_valid, lcl.rx_first, lcl.tx_request, lcl.busy, lcl.stop_seen} !== 13'h0)
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b required 00/00000", lcl.rx_data,
               lcl.rx_valid, lcl.rx_first, lcl.tx_request, lcl.busy, lcl.stop_seen);
    else pass_cnt++;
    total_cnt++;
    if ({scl, sda} !== 2'b11) $display("FAIL reset_lines: got scl/sda=%b%b required 11", scl, sda);
    else pass_cnt++;
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] e;
    int rx0, st0;
    rx0 = rx_cnt;
    st0 = stop_cnt;
    total_cnt++;
    if (lcl.busy !== 1'b0) $display("FAIL write_busy_before: got %b required 0", lcl.busy);
    else pass_cnt++;
    m_start();
    m_write_byte(8'h84, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL write_addr_ack: got %b required 1", ack); else pass_cnt++;
    total_cnt++;
    if (lcl.busy !== 1'b1) $display("FAIL write_busy_after_ack: got %b required 1", lcl.busy);
    else pass_cnt++;
    m_write_byte(8'hA5, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL write_byte0_ack: got %b required 1", ack); else pass_cnt++;
    m_write_byte(8'h3C, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL write_byte1_ack: got %b required 1", ack); else pass_cnt++;
    m_stop();
    tick(10);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    total_cnt++;
    if (rx_cnt - rx0 !== 2) $display("FAIL write_rx_count: got %0d required 2", rx_cnt - rx0);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (rx_log[rx0 + k] !== e)
        $display("FAIL write_rx_data%0d: got %h required %h", k, rx_log[rx0 + k], e);
      else pass_cnt++;
      total_cnt++;
      if (rx_first_log[rx0 + k] !== (k == 0))
        $display("FAIL write_rx_first%0d: got %b required %b", k, rx_first_log[rx0 + k], k == 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (stop_cnt - st0 !== 1) $display("FAIL write_stop_seen: got %0d required 1", stop_cnt - st0);
    else pass_cnt++;
    total_cnt++;
    if (lcl.busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b required 0", lcl.busy);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int w, rq0, sl0;
    resp_en = 1'b1;
    rq0 = req_rises;
    sl0 = stretch_low_cnt;
    m_start();
    m_write_byte(8'h85, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL read_addr_ack: got %b required 1", ack); else pass_cnt++;
    m_read_byte(1'b1, d, w);
    total_cnt++;
    if (d !== 8'h5A) $display("FAIL read_byte0: got %h required 5a", d); else pass_cnt++;
    total_cnt++;
    if (w <= 10) $display("FAIL read_stretch0: got wait %0d required >10", w); else pass_cnt++;
    m_read_byte(1'b0, d, w);
    total_cnt++;
    if (d !== 8'hF0) $display("FAIL read_byte1: got %h required f0", d); else pass_cnt++;
    total_cnt++;
    if (w <= 10) $display("FAIL read_stretch1: got wait %0d required >10", w); else pass_cnt++;
    m_stop();
    tick(40);
    total_cnt++;
    if (req_rises - rq0 !== 2) $display("FAIL read_requests: got %0d required 2", req_rises - rq0);
    else pass_cnt++;
    total_cnt++;
    if (stretch_low_cnt - sl0 !== 2)
      $display("FAIL read_scl_held: got %0d required 2", stretch_low_cnt - sl0);
    else pass_cnt++;
    total_cnt++;
    if (lcl.busy !== 1'b0) $display("FAIL read_busy_after_stop: got %b required 0", lcl.busy);
    else pass_cnt++;
  endtask

  task automatic test_mismatch();
    logic ack;
    int rx0, st0, bz0, sd0;
    rx0 = rx_cnt;
    st0 = stop_cnt;
    bz0 = busy_hi_cnt;
    sd0 = dut_sda_low_cnt;
    m_start();
    m_write_byte(8'h86, ack);
    total_cnt++;
    if (ack !== 1'b0) $display("FAIL mismatch_addr_ack: got %b required 0", ack); else pass_cnt++;
    m_write_byte(8'h11, ack);
    total_cnt++;
    if (ack !== 1'b0) $display("FAIL mismatch_data_ack: got %b required 0", ack); else pass_cnt++;
    m_stop();
    tick(10);
    total_cnt++;
    if (rx_cnt - rx0 !== 0) $display("FAIL mismatch_rx: got %0d required 0", rx_cnt - rx0);
    else pass_cnt++;
    total_cnt++;
    if (busy_hi_cnt - bz0 !== 0) $display("FAIL mismatch_busy: got %0d required 0", busy_hi_cnt - bz0);
    else pass_cnt++;
    total_cnt++;
    if (dut_sda_low_cnt - sd0 !== 0)
      $display("FAIL mismatch_sda_driven: got %0d required 0", dut_sda_low_cnt - sd0);
    else pass_cnt++;
    total_cnt++;
    if (stop_cnt - st0 !== 1) $display("FAIL mismatch_stop_seen: got %0d required 1", stop_cnt - st0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    int w, rx0;
    rx0 = rx_cnt;
    m_start();
    m_write_byte(8'h84, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rs_addr_w_ack: got %b required 1", ack); else pass_cnt++;
    m_write_byte(8'h07, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rs_data_ack: got %b required 1", ack); else pass_cnt++;
    total_cnt++;
    if (rx_cnt - rx0 !== 1 || rx_log[rx0] !== 8'h07 || rx_first_log[rx0] !== 1'b1)
      $display("FAIL rs_rx: got count %0d data %h first %b required 1 07 1",
               rx_cnt - rx0, rx_log[rx0], rx_first_log[rx0]);
    else pass_cnt++;
    total_cnt++;
    if (lcl.busy !== 1'b1) $display("FAIL rs_busy_before: got %b required 1", lcl.busy);
    else pass_cnt++;
    m_rstart();
    total_cnt++;
    if (lcl.busy !== 1'b0) $display("FAIL rs_busy_dropped: got %b required 0", lcl.busy);
    else pass_cnt++;
    m_write_byte(8'h85, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rs_addr_r_ack: got %b required 1", ack); else pass_cnt++;
    total_cnt++;
    if (lcl.busy !== 1'b1) $display("FAIL rs_busy_rerise: got %b required 1", lcl.busy);
    else pass_cnt++;
    m_read_byte(1'b0, d, w);
    total_cnt++;
    if (d !== 8'hC3) $display("FAIL rs_read_byte: got %h required c3", d); else pass_cnt++;
    m_stop();
    tick(10);
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    resp_en = 1'b0;
    m_start();
    m_write_byte(8'h85, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rst_addr_ack: got %b required 1", ack); else pass_cnt++;
    m_scl_low = 1'b0;
    tick(10);
    total_cnt++;
    if (scl !== 1'b0 || lcl.tx_request !== 1'b1)
      $display("FAIL rst_stretching: got scl %b tx_request %b required 0 1", scl, lcl.tx_request);
    else pass_cnt++;
    #3;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({scl, sda} !== 2'b11) $display("FAIL rst_lines_released: got %b%b required 11", scl, sda);
    else pass_cnt++;
    total_cnt++;
    if (lcl.tx_request !== 1'b0 || lcl.busy !== 1'b0)
      $display("FAIL rst_outputs: got tx_request %b busy %b required 0 0", lcl.tx_request, lcl.busy);
    else pass_cnt++;
    tick(3);
    reset = 1'b1;
    tick(5);
    m_start();
    m_write_byte(8'h84, ack);
    total_cnt++;
    if (ack !== 1'b1) $display("FAIL rst_after_ack: got %b required 1", ack); else pass_cnt++;
    m_stop();
    tick(10);
  endtask

  initial begin
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    reset = 1'b0;
    tx_src[0] = 8'h5A;
    tx_src[1] = 8'hF0;
    tx_src[2] = 8'hC3;
    tx_src[3] = 8'hFF;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    resp_en = 1'b1;
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
